if_stage: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and issues word-aligned requests to an instruction memory that has variable latency and returns responses in order.
- Buffers returned instructions in a small fetch queue.
- Presents {instr, pc, pc+4} to decode through a valid/ready handshake.
- Supports a branch/jump redirect that flushes the queue and discards in-flight responses.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions; flush overrides push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fq_entry_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 wdata,
  input  logic             pop,
  input  logic             flush,
  output T                 rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush))
    else $error("fetch_fifo: push into full queue");

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, in-order variable-latency imem interface,
// fetch queue and redirect drain, feeding decode over valid/ready.
module if_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  parameter int                FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload is held stable while valid && !ready.

  localparam int CW    = $clog2(FQ_DEPTH) + 1;
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic              fq_push, fq_pop, fq_flush;
  logic              fq_full, fq_empty;
  logic [CNT_W-1:0]  fq_count;
  entry_t            fq_wdata, fq_rdata;

  logic              credit_ok;
  logic              req_fire;
  logic              resp_live;

  // In-flight requests (including ones awaiting drop) reserve queue slots.
  assign credit_ok      = (int'(out_q) + int'(fq_count)) < FQ_DEPTH;
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q & WORD_MASK;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign resp_live      = imem_resp_valid && (out_q != '0);

  always_comb begin
    pc_d     = pc_q;
    tag_d    = tag_q;
    out_d    = out_q;
    drop_d   = drop_q;
    fq_push  = 1'b0;
    fq_pop   = 1'b0;
    fq_flush = 1'b0;
    fq_wdata = '{instr: imem_resp_data, pc: tag_q};
    if (redirect_valid) begin
      pc_d     = redirect_pc & WORD_MASK;
      tag_d    = redirect_pc & WORD_MASK;
      fq_flush = 1'b1;
      out_d    = out_q - CW'(resp_live);
      drop_d   = out_q - CW'(resp_live);
    end else begin
      fq_pop = !fq_empty && id_ready;
      if (req_fire) pc_d = pc_q + PC_STEP;
      out_d = out_q + CW'(req_fire) - CW'(resp_live);
      if (resp_live) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          fq_push = 1'b1;
          tag_d   = tag_q + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      tag_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      tag_q  <= tag_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (entry_t)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fq_push),
    .wdata (fq_wdata),
    .pop   (fq_pop),
    .flush (fq_flush),
    .rdata (fq_rdata),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  assign id_valid    = !fq_empty;
  assign id_instr    = fq_empty ? NOP_INSTR : fq_rdata.instr;
  assign id_pc       = fq_empty ? '0 : fq_rdata.pc;
  assign id_pc_plus4 = fq_empty ? '0 : fq_rdata.pc + PC_STEP;

  assert property (@(posedge clk) disable iff (rst) drop_q <= out_q)
    else $error("if_stage: drop count exceeds outstanding");
  assert property (@(posedge clk) disable iff (rst) !(fq_push && fq_full && !fq_pop))
    else $error("if_stage: fetch queue overflow");

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle table, directed corner sequences, random traffic
// checked against an in-order memory model and an expected-entry queue.
module tb_if_stage;

  localparam int          ADDR_W   = 32;
  localparam int          FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  if_stage #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          due;
    bit          stale;
    bit          orphan;
  } mreq_t;

  typedef struct {
    logic        id_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        id_valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  mreq_t       pend_q[$];
  logic [63:0] exp_q[$];
  vec_t        vecs[5];

  int          n_tests, n_fail, cyc, req_cnt, mem_lat;
  bit          resp_now, found;
  logic [31:0] model_pc;
  logic        drv_rst, drv_redir, drv_id_ready, drv_req_ready;
  logic [31:0] drv_redir_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2002_0005;
    if (a == 32'h4) return 32'h2003_0007;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit orphans_pending();
    foreach (pend_q[i]) if (pend_q[i].orphan) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_cycle();
    rst            = drv_rst;
    redirect_valid = drv_redir;
    redirect_pc    = drv_redir_pc;
    id_ready       = drv_id_ready;
    imem_req_ready = drv_req_ready;
    resp_now       = 1'b0;
    if (pend_q.size() != 0) begin
      if (pend_q[0].due <= cyc) resp_now = 1'b1;
    end
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(pend_q[0].addr) : 32'h0;
    #3;
  endtask

  // Scoreboard check and model update at mid-cycle, then advance one clock.
  task automatic end_cycle();
    int          live;
    bit          exp_rv, exp_iv;
    mreq_t       m;
    live = 0;
    foreach (pend_q[i]) if (!pend_q[i].orphan) live++;
    exp_rv = !drv_rst && !drv_redir && ((live + exp_q.size()) < FQ_DEPTH);
    chk("imem_req_valid", imem_req_valid, exp_rv);
    if (exp_rv && imem_req_valid) chk("imem_req_addr", imem_req_addr, model_pc);
    exp_iv = (exp_q.size() != 0);
    chk("id_valid", id_valid, exp_iv);
    if (exp_iv && id_valid) begin
      chk("id_instr", id_instr, exp_q[0][63:32]);
      chk("id_pc", id_pc, exp_q[0][31:0]);
      chk("id_pc_plus4", id_pc_plus4, exp_q[0][31:0] + 32'd4);
    end
    if (imem_req_valid && imem_req_ready) req_cnt++;

    if (drv_rst) begin
      if (resp_now) void'(pend_q.pop_front());
      foreach (pend_q[i]) pend_q[i].orphan = 1'b1;
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (drv_redir) begin
      if (resp_now) void'(pend_q.pop_front());
      foreach (pend_q[i]) if (!pend_q[i].orphan) pend_q[i].stale = 1'b1;
      exp_q.delete();
      model_pc = drv_redir_pc & 32'hFFFF_FFFC;
    end else begin
      if (exp_iv && drv_id_ready) void'(exp_q.pop_front());
      if (resp_now) begin
        m = pend_q.pop_front();
        if (!m.stale && !m.orphan) exp_q.push_back({mem_word(m.addr), m.pc});
      end
      if (imem_req_valid && imem_req_ready) begin
        m.addr   = imem_req_addr;
        m.pc     = model_pc;
        m.due    = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat);
        m.stale  = 1'b0;
        m.orphan = 1'b0;
        pend_q.push_back(m);
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    begin_cycle();
    end_cycle();
  endtask

  task automatic do_reset();
    drv_rst   = 1'b1;
    drv_redir = 1'b0;
    step();
    drv_rst       = 1'b0;
    drv_req_ready = 1'b0;
    for (int i = 0; i < 10 && orphans_pending(); i++) begin
      begin_cycle();
      chk("reset_drain_id_valid", id_valid, 1'b0);
      end_cycle();
    end
    drv_req_ready = 1'b1;
    req_cnt       = 0;
  endtask

  task automatic wait_id(input string name, input logic [31:0] want_pc);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      begin_cycle();
      if (id_valid) begin
        found = 1'b1;
        chk({name, "_pc"}, id_pc, want_pc);
        chk({name, "_instr"}, id_instr, mem_word(want_pc));
      end
      end_cycle();
    end
    chk({name, "_seen"}, found, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{id_ready: 1, req_valid: 1, req_addr: 32'h0, id_valid: 0, instr: 32'h0,         pc: 32'h0};
    vecs[1] = '{id_ready: 1, req_valid: 1, req_addr: 32'h4, id_valid: 0, instr: 32'h0,         pc: 32'h0};
    vecs[2] = '{id_ready: 1, req_valid: 0, req_addr: 32'h0, id_valid: 1, instr: 32'h2002_0005, pc: 32'h0};
    vecs[3] = '{id_ready: 1, req_valid: 1, req_addr: 32'h8, id_valid: 1, instr: 32'h2003_0007, pc: 32'h4};
    vecs[4] = '{id_ready: 1, req_valid: 1, req_addr: 32'hC, id_valid: 0, instr: 32'h0,         pc: 32'h0};

    n_tests = 0; n_fail = 0; cyc = 0; req_cnt = 0; mem_lat = 1;
    model_pc = RESET_PC;
    drv_rst = 1'b1; drv_redir = 1'b0; drv_redir_pc = 32'h0;
    drv_id_ready = 1'b1; drv_req_ready = 1'b1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(posedge clk);
    #1;

    // reset state
    begin_cycle();
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    end_cycle();
    drv_rst = 1'b0;

    // 1-cycle memory, decode always ready: cycle table
    for (int i = 0; i < 5; i++) begin
      drv_id_ready = vecs[i].id_ready;
      begin_cycle();
      chk("t1_req_valid", imem_req_valid, vecs[i].req_valid);
      if (vecs[i].req_valid) chk("t1_req_addr", imem_req_addr, vecs[i].req_addr);
      chk("t1_id_valid", id_valid, vecs[i].id_valid);
      if (vecs[i].id_valid) begin
        chk("t1_id_instr", id_instr, vecs[i].instr);
        chk("t1_id_pc", id_pc, vecs[i].pc);
        chk("t1_id_pc_plus4", id_pc_plus4, vecs[i].pc + 32'd4);
      end
      end_cycle();
    end

    // decode stalled: credit cap of two, then resume at 0x8
    do_reset();
    mem_lat = 1;
    drv_id_ready = 1'b0;
    repeat (10) step();
    chk("t2_req_count", req_cnt, 2);
    begin_cycle();
    chk("t2_req_valid_held_low", imem_req_valid, 1'b0);
    chk("t2_id_pc_stable", id_pc, 32'h0);
    chk("t2_id_instr_stable", id_instr, 32'h2002_0005);
    end_cycle();
    drv_id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      begin_cycle();
      if (imem_req_valid && imem_req_ready) begin
        found = 1'b1;
        chk("t2_resume_addr", imem_req_addr, 32'h8);
      end
      end_cycle();
    end
    chk("t2_resume_seen", found, 1'b1);

    // redirect with two requests in flight (latency 3)
    do_reset();
    mem_lat = 3;
    step();
    step();
    drv_redir = 1'b1; drv_redir_pc = 32'h0000_0100;
    begin_cycle();
    chk("t3_no_req_on_redirect", imem_req_valid, 1'b0);
    end_cycle();
    drv_redir = 1'b0;
    wait_id("t3_first", 32'h0000_0100);

    // redirect coinciding with a response and a ready decode
    do_reset();
    mem_lat = 1;
    step();
    step();
    drv_redir = 1'b1; drv_redir_pc = 32'h0000_0200;
    begin_cycle();
    chk("t4_id_valid_before", id_valid, 1'b1);
    end_cycle();
    drv_redir = 1'b0;
    begin_cycle();
    chk("t4_id_valid_after", id_valid, 1'b0);
    chk("t4_req_valid", imem_req_valid, 1'b1);
    chk("t4_req_addr", imem_req_addr, 32'h0000_0200);
    end_cycle();
    wait_id("t4_first", 32'h0000_0200);

    // unaligned redirect target
    drv_redir = 1'b1; drv_redir_pc = 32'h0000_0103;
    step();
    drv_redir = 1'b0;
    begin_cycle();
    chk("t5_req_addr", imem_req_addr, 32'h0000_0100);
    end_cycle();
    wait_id("t5_first", 32'h0000_0100);

    // reset with two requests in flight; stale words then arrive
    do_reset();
    mem_lat = 3;
    step();
    step();
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0;
    drv_req_ready = 1'b0;
    begin_cycle();
    chk("t6_req_addr", imem_req_addr, RESET_PC);
    chk("t6_id_valid", id_valid, 1'b0);
    end_cycle();
    for (int i = 0; i < 10 && orphans_pending(); i++) begin
      begin_cycle();
      chk("t6_stale_ignored", id_valid, 1'b0);
      end_cycle();
    end
    drv_req_ready = 1'b1;
    wait_id("t6_first", RESET_PC);

    // random traffic with redirects, including PC wrap-around
    do_reset();
    mem_lat = 0;
    for (int i = 0; i < 800; i++) begin
      drv_id_ready  = ($urandom_range(0, 3) != 0);
      drv_req_ready = ($urandom_range(0, 4) != 0);
      drv_redir     = ($urandom_range(0, 24) == 0);
      drv_redir_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 1023));
      step();
    end
    drv_redir = 1'b0;
    drv_id_ready = 1'b1;
    drv_req_ready = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
